// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the FIFO-buffered SPI master.
//   spi_state_e  - serial engine states
//   IRQ_*        - bit positions inside irq_status / irq_en / irq_clear
//   SPI_MODE*    - {cpol, cpha} encodings of the four SPI modes
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_e;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_RXAV = 1;
    localparam int IRQ_OVR  = 2;
    localparam int IRQ_TXOF = 3;

    // Bits that are held in the sticky status register; rx_avail is a live level.
    localparam logic [3:0] IRQ_STICKY_MASK = 4'b1101;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous first-word fall-through FIFO.
//   clk, rst_n  - clock, async active-low reset (contents cleared to zero)
//   push        - write push_data when accepted
//   pop         - advance head; ignored when empty
//   pop_data    - current head (holds when empty)
//   full, empty - flags from the pre-edge occupancy
//   level       - occupancy 0..DEPTH
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. Callers that must reject writes on full regardless gate push with
// !full themselves.
module spi_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign level    = cnt;
    assign pop_data = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: SPI master with TX/RX FIFOs, runtime CPOL/CPHA, fixed
// SCLK divider, chip-select-held bursts and a maskable sticky interrupt.
//   clk, rst_n              - system clock, async active-low reset
//   cfg_cpol, cfg_cpha      - SPI mode, latched at frame start
//   slave_sel               - target slave index, latched at frame start
//   tx_wr_en/tx_wr_data     - host push into TX FIFO; tx_full, tx_level
//   rx_rd_en/rx_rd_data     - host pop of RX FIFO (fall-through); rx_empty, rx_level
//   irq_en, irq_clear       - interrupt mask, write-1-to-clear
//   irq_status, irq         - raw status, registered masked OR
//   busy                    - engine not idle
//   sclk, mosi, miso, ss_n  - SPI pins
module spi_master_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int SSW        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic [SSW-1:0]        slave_sel,
    input  logic                  tx_wr_en,
    input  logic [DATA_WIDTH-1:0] tx_wr_data,
    output logic                  tx_full,
    output logic [LW-1:0]         tx_level,
    input  logic                  rx_rd_en,
    output logic [DATA_WIDTH-1:0] rx_rd_data,
    output logic                  rx_empty,
    output logic [LW-1:0]         rx_level,
    input  logic [3:0]            irq_en,
    input  logic [3:0]            irq_clear,
    output logic [3:0]            irq_status,
    output logic                  irq,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);

    localparam int DW    = DATA_WIDTH;
    localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW    = $clog2(2 * DW);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DW - 1);

    spi_state_e       state, state_d;
    logic [DIVW-1:0]  div_cnt;
    logic [HW-1:0]    half_cnt;
    logic [HW-1:0]    edge_half;
    logic             div_done;
    logic             cpol_l, cpha_l;
    logic [SSW-1:0]   sel_l;
    logic [DW-1:0]    tx_sr, rx_sr;
    logic [DW-1:0]    tx_head;
    logic             tx_empty, rx_full;
    logic             tx_pop, rx_push, start, ss_release, edge_en;
    logic             cpha_eff, sample;
    logic [3:0]       sts, sts_set;

    function automatic logic [NUM_SLAVES-1:0] ss_decode(input logic [SSW-1:0] s);
        for (int i = 0; i < NUM_SLAVES; i++) ss_decode[i] = !(s == SSW'(i));
    endfunction

    // Host writes on full are rejected outright, even against a same-cycle pop.
    spi_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_wr_en && !tx_full),
        .push_data (tx_wr_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    // A completed word may enter a full RX FIFO when the host pops that cycle.
    spi_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_sr),
        .pop       (rx_rd_en),
        .pop_data  (rx_rd_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign div_done = (div_cnt == DIVW'(CLK_DIV - 1));
    assign busy     = (state != IDLE);
    // A burst continuation keeps the mode latched at the first frame.
    assign cpha_eff = (state == IDLE) ? cfg_cpha : cpha_l;
    // Even half-periods open with the leading edge; CPHA picks which edge samples.
    assign sample   = ~edge_half[0] ^ cpha_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        start      = 1'b0;
        ss_release = 1'b0;
        edge_en    = 1'b0;
        edge_half  = half_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    start   = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (div_done) begin
                    edge_en   = 1'b1;
                    edge_half = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    if (half_cnt == LAST_HALF) begin
                        rx_push = 1'b1;
                        state_d = TRAIL;
                    end else begin
                        edge_en = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (div_done) begin
                    if (!tx_empty && slave_sel == sel_l) begin
                        tx_pop  = 1'b1;
                        start   = 1'b1;
                        state_d = LEAD;
                    end else begin
                        ss_release = 1'b1;
                        state_d    = GAP;
                    end
                end
            end
            GAP: begin
                if (div_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            sel_l    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            if (state == IDLE || div_done) div_cnt <= '0;
            else                           div_cnt <= div_cnt + 1'b1;

            if (state == IDLE) sclk <= cfg_cpol;
            else if (edge_en)  sclk <= ~sclk;

            if (start) begin
                if (state == IDLE) begin
                    cpol_l <= cfg_cpol;
                    cpha_l <= cfg_cpha;
                    sel_l  <= slave_sel;
                    ss_n   <= ss_decode(slave_sel);
                end
                // CPHA=0 puts the MSB out now, so the register holds the rest.
                if (cpha_eff) begin
                    tx_sr <= tx_head;
                end else begin
                    tx_sr <= {tx_head[DW-2:0], 1'b0};
                    mosi  <= tx_head[DW-1];
                end
            end

            if (edge_en) begin
                half_cnt <= edge_half;
                if (sample) begin
                    rx_sr <= {rx_sr[DW-2:0], miso};
                end else begin
                    mosi  <= tx_sr[DW-1];
                    tx_sr <= {tx_sr[DW-2:0], 1'b0};
                end
            end

            if (ss_release) ss_n <= '1;
        end
    end

    always_comb begin
        sts_set           = '0;
        sts_set[IRQ_DONE] = rx_push;
        sts_set[IRQ_OVR]  = rx_push && rx_full && !rx_rd_en;
        sts_set[IRQ_TXOF] = tx_wr_en && tx_full;
    end

    always_comb begin
        irq_status           = sts;
        irq_status[IRQ_RXAV] = !rx_empty;
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts <= '0;
            irq <= 1'b0;
        end else begin
            sts <= ((sts & ~irq_clear) | sts_set) & IRQ_STICKY_MASK;
            irq <= |(irq_status & irq_en);
        end
    end

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: randomized self-checking bench for spi_master_fifo.
// A behavioural SPI slave watches the pins, collects MOSI words and returns a
// chosen word on MISO (or loops MOSI back); expectations come from the tx
// words, slave words and FIFO capacity rules.
module tb_spi_master_fifo;

    localparam int DW    = 16;
    localparam int NS    = 2;
    localparam int FD    = 8;
    localparam int CD    = 4;
    localparam int SSW   = 1;
    localparam int LW    = $clog2(FD) + 1;
    localparam int FRAME = (2 * DW + 2) * CD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_cpol, cfg_cpha;
    logic [SSW-1:0] slave_sel;
    logic          tx_wr_en;
    logic [DW-1:0] tx_wr_data;
    logic          tx_full;
    logic [LW-1:0] tx_level;
    logic          rx_rd_en;
    logic [DW-1:0] rx_rd_data;
    logic          rx_empty;
    logic [LW-1:0] rx_level;
    logic [3:0]    irq_en, irq_clear, irq_status;
    logic          irq, busy, sclk, mosi, miso;
    logic [NS-1:0] ss_n;

    logic          loop_mode;
    logic          slv_miso;
    logic [DW-1:0] slv_word;

    assign miso = loop_mode ? mosi : slv_miso;

    always #5 clk = ~clk;

    spi_master_fifo #(.DATA_WIDTH(DW), .NUM_SLAVES(NS), .FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .slave_sel(slave_sel), .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
        .tx_full(tx_full), .tx_level(tx_level), .rx_rd_en(rx_rd_en),
        .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
        .irq_en(irq_en), .irq_clear(irq_clear), .irq_status(irq_status), .irq(irq),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave / pin monitor ----------------
    typedef struct {
        logic [NS-1:0] val;
        int            len;
    } ss_rec_t;

    ss_rec_t       ss_log[$];
    logic [DW-1:0] mosi_q[$];
    logic          m_prev_act = 1'b0;
    logic          m_prev_sclk = 1'b0;
    logic          m_cpol, m_cpha;
    logic [NS-1:0] m_val;
    int            m_len, m_k, m_nsamp, m_glitch = 0;
    logic [DW-1:0] m_cap;

    always @(negedge clk) begin
        if (ss_n != '1) begin
            if (!m_prev_act) begin
                m_cpol = cfg_cpol; m_cpha = cfg_cpha; m_val = ss_n;
                m_len = 0; m_k = 0; m_nsamp = 0; m_cap = '0;
                if (!m_cpha) begin slv_miso = slv_word[DW-1]; m_k = 1; end
            end
            m_len++;
            if (ss_n != m_val) m_glitch++;
            if (sclk != m_prev_sclk) begin
                if ((sclk != m_cpol) ^ m_cpha) begin
                    m_cap = {m_cap[DW-2:0], mosi};
                    m_nsamp++;
                    if (m_nsamp % DW == 0) mosi_q.push_back(m_cap);
                end else begin
                    slv_miso = slv_word[DW-1-(m_k % DW)];
                    m_k++;
                end
            end
        end else if (m_prev_act) begin
            ss_log.push_back('{val: m_val, len: m_len});
        end
        m_prev_act  = (ss_n != '1);
        m_prev_sclk = sclk;
    end

    // ---------------- helpers ----------------
    task automatic push(input logic [DW-1:0] w);
        tx_wr_en = 1'b1; tx_wr_data = w;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
        chk(tag, rx_rd_data, exp);
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
    endtask

    task automatic mosi_chk(input logic [DW-1:0] exp);
        if (mosi_q.size() == 0) chk("mosi_words", 0, 1);
        else chk("mosi_stream", mosi_q.pop_front(), exp);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || tx_level != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", (n >= budget), 0);
        @(negedge clk);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", (n >= 20), 0);
    endtask

    task automatic clr_irq(input logic [3:0] c);
        irq_clear = c;
        @(negedge clk);
        irq_clear = '0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        {cfg_cpol, cfg_cpha} = m;
        repeat (2) @(negedge clk);
        chk("sclk_idle", sclk, m[1]);
    endtask

    task automatic clr_logs();
        ss_log.delete();
        mosi_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] w, words[$], exp_rx[$];

    initial begin
        rst_n = 1'b0; cfg_cpol = 0; cfg_cpha = 0; slave_sel = '0;
        tx_wr_en = 0; tx_wr_data = '0; rx_rd_en = 0;
        irq_en = '0; irq_clear = '0; loop_mode = 1'b1; slv_word = '0; slv_miso = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_ss_n", ss_n, 2'b11);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_irq_status", irq_status, 0);
        chk("rst_rx_data", rx_rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0 loopback, single frame
        set_mode(2'b00);
        clr_logs();
        push(16'hAA55);
        wait_done(400);
        chk("m0_ss_cnt", ss_log.size(), 1);
        if (ss_log.size() > 0) begin
            chk("m0_ss_val", ss_log[0].val, 2'b10);
            chk("m0_ss_len", ss_log[0].len, FRAME);
        end
        mosi_chk(16'hAA55);
        chk("m0_done", irq_status[0], 1);
        chk("m0_rx_level", rx_level, 1);
        pop_chk("m0_rx", 16'hAA55);
        clr_irq(4'hF);

        // all four modes against the slave model
        loop_mode = 1'b0;
        for (int m = 0; m < 4; m++) begin
            logic [1:0] mb;
            mb = m[1:0];
            set_mode(mb);
            for (int r = 0; r < 3; r++) begin
                slv_word = (r == 0) ? 16'h55AA : DW'($urandom);
                w = DW'($urandom);
                clr_logs();
                push(w);
                wait_done(400);
                mosi_chk(w);
                chk("mode_sclk_idle", sclk, mb[1]);
                pop_chk("mode_rx", slv_word);
            end
        end

        // burst on slave 1, loopback
        set_mode(2'b00);
        loop_mode = 1'b1;
        slave_sel = 1'b1;
        clr_logs();
        push(16'h0000); push(16'h1111); push(16'h2222);
        wait_done(1500);
        chk("burst_ss_cnt", ss_log.size(), 1);
        if (ss_log.size() > 0) begin
            chk("burst_ss_val", ss_log[0].val, 2'b01);
            chk("burst_ss_len", ss_log[0].len, 3 * FRAME);
        end
        chk("burst_rx_level", rx_level, 3);
        mosi_chk(16'h0000); mosi_chk(16'h1111); mosi_chk(16'h2222);
        pop_chk("burst_rx0", 16'h0000);
        pop_chk("burst_rx1", 16'h1111);
        pop_chk("burst_rx2", 16'h2222);

        // slave change mid-burst breaks the burst
        slave_sel = 1'b0;
        clr_logs();
        words.delete();
        for (int i = 0; i < 2; i++) begin
            w = DW'($urandom);
            words.push_back(w);
            push(w);
        end
        repeat (10) @(negedge clk);
        slave_sel = 1'b1;
        wait_done(1000);
        chk("selchg_ss_cnt", ss_log.size(), 2);
        if (ss_log.size() == 2) begin
            chk("selchg_val0", ss_log[0].val, 2'b10);
            chk("selchg_len0", ss_log[0].len, FRAME);
            chk("selchg_val1", ss_log[1].val, 2'b01);
            chk("selchg_len1", ss_log[1].len, FRAME);
        end
        pop_chk("selchg_rx0", words[0]);
        pop_chk("selchg_rx1", words[1]);
        clr_irq(4'hF);

        // TX overflow and RX overrun
        slave_sel = 1'b0;
        irq_en = 4'b1100;
        words.delete();
        w = DW'($urandom);
        words.push_back(w);
        push(w);
        wait_busy();
        for (int i = 0; i < FD + 1; i++) begin
            w = DW'($urandom);
            if (i < FD) words.push_back(w);   // the write beyond capacity is lost
            push(w);
        end
        chk("ovf_tx_level", tx_level, FD);
        chk("ovf_tx_full", tx_full, 1);
        chk("ovf_status3", irq_status[3], 1);
        tx_wr_en = 1'b1; irq_clear = 4'b1000;
        @(negedge clk);
        tx_wr_en = 1'b0; irq_clear = '0;
        chk("ovf_set_beats_clr", irq_status[3], 1);
        wait_done(3000);
        exp_rx.delete();
        foreach (words[i]) if (exp_rx.size() < FD) exp_rx.push_back(words[i]);
        chk("ovr_rx_level", rx_level, FD);
        chk("ovr_status2", irq_status[2], 1);
        chk("ovr_irq", irq, 1);
        clr_irq(4'b1100);
        chk("ovr_cleared", irq_status[3:2], 2'b00);
        @(negedge clk);
        chk("ovr_irq_drop", irq, 0);
        foreach (exp_rx[i]) pop_chk("ovr_rx", exp_rx[i]);
        chk("ovr_rx_empty", rx_empty, 1);
        clr_irq(4'hF);

        // interrupt masking
        irq_en = '0;
        w = DW'($urandom);
        push(w);
        wait_done(400);
        chk("mask_status0", irq_status[0], 1);
        chk("mask_irq_off", irq, 0);
        irq_en = 4'b0001;
        chk("mask_irq_lag", irq, 0);
        @(negedge clk);
        chk("mask_irq_on", irq, 1);
        pop_chk("mask_rx", w);
        clr_irq(4'hF);
        irq_en = '0;

        // reset in the middle of SHIFT
        push(DW'($urandom)); push(DW'($urandom)); push(DW'($urandom));
        wait_busy();
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", ss_n, 2'b11);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_level", tx_level, 0);
        chk("mid_rst_rx_level", rx_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_logs();
        set_mode(2'b00);
        push(16'h1234);
        wait_done(400);
        chk("post_rst_rx_level", rx_level, 1);
        mosi_chk(16'h1234);
        pop_chk("post_rst_rx", 16'h1234);

        chk("ss_stable", m_glitch, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
